tlb_op_ctrl: RTL and testbench

//  Sequences LoongArch TLB-maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) onto the 16-entry TLB.

---
 rtl/tlb_op_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLB maintenance ops (TLBSRCH, TLBRD, TLBWR, TLBFILL,
// INVTLB) onto the TLB ports and returns search/read status to the CSR file.
// Every op runs IDLE -> EXEC -> DONE: accepted at cycle N, TLB action at N+1,
// done pulse at N+2. All operands are captured at accept.
//
// Ports (groups):
//   clk_i, reset_i          clock, synchronous active-high reset
//   op_*_i / op_ready_o     request handshake, op_code 0..4 (5..7 reserved)
//   inv_*_i                 INVTLB op, asid, vppn
//   csr_*_i                 ASID, TLBEHI, TLBIDX, TLBELO0/1 CSR fields
//   tlb_s1_*                borrowed lookup port (search / invalidate)
//   tlb_r_*                 read port
//   tlb_w*_o                write port
//   tlb_inv_*_o             invalidate port
//   csr_srch_*_o, csr_rd_*_o  result write-back to CSR file
//   done_o, op_err_o        completion pulse, error flag
//
// Build option: define TLB_FILL_LFSR_EN to draw the TLBFILL victim index from
// a free-running 16-bit LFSR instead of the round-robin counter.
//
// state | meaning
// IDLE  | op_ready_o = 1, waiting for op_valid_i
// EXEC  | TLB port action for the latched op
// DONE  | done_o pulse, CSR result strobes
module tlb_op_ctrl #(
   parameter int TLBNUM = 16,
   localparam int IW = $clog2(TLBNUM)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          op_valid_i,
   output logic          op_ready_o,
   input  logic [2:0]    op_code_i,
   input  logic [4:0]    inv_op_i,
   input  logic [9:0]    inv_asid_i,
   input  logic [18:0]   inv_vppn_i,
   input  logic [9:0]    csr_asid_i,
   input  logic [18:0]   csr_ehi_vppn_i,
   input  logic [IW-1:0] csr_idx_i,
   input  logic [5:0]    csr_ps_i,
   input  logic          csr_ne_i,
   input  logic [31:0]   csr_elo0_i,
   input  logic [31:0]   csr_elo1_i,
   output logic          tlb_s1_sel_o,
   output logic [18:0]   tlb_s1_vppn_o,
   output logic [9:0]    tlb_s1_asid_o,
   input  logic          tlb_s1_found_i,
   input  logic [IW-1:0] tlb_s1_index_i,
   output logic [IW-1:0] tlb_r_index_o,
   input  logic          tlb_r_e_i,
   output logic          tlb_we_o,
   output logic [IW-1:0] tlb_w_index_o,
   output logic          tlb_w_e_o,
   output logic [5:0]    tlb_w_ps_o,
   output logic [18:0]   tlb_w_vppn_o,
   output logic [9:0]    tlb_w_asid_o,
   output logic          tlb_w_g_o,
   output logic [19:0]   tlb_w_ppn0_o,
   output logic [1:0]    tlb_w_plv0_o,
   output logic [1:0]    tlb_w_mat0_o,
   output logic          tlb_w_d0_o,
   output logic          tlb_w_v0_o,
   output logic [19:0]   tlb_w_ppn1_o,
   output logic [1:0]    tlb_w_plv1_o,
   output logic [1:0]    tlb_w_mat1_o,
   output logic          tlb_w_d1_o,
   output logic          tlb_w_v1_o,
   output logic          tlb_inv_valid_o,
   output logic [4:0]    tlb_inv_op_o,
   output logic          csr_srch_we_o,
   output logic          csr_srch_ne_o,
   output logic [IW-1:0] csr_srch_index_o,
   output logic          csr_rd_we_o,
   output logic          csr_rd_ne_o,
   output logic          done_o,
   output logic          op_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   state_e        state_q;
   logic [2:0]    op_q;
   logic          err_q;
   logic          s1_sel_q, we_q, inv_valid_q;
   logic [18:0]   s1_vppn_q, w_vppn_q;
   logic [9:0]    s1_asid_q, w_asid_q;
   logic [IW-1:0] r_index_q, w_index_q, srch_index_q;
   logic [5:0]    w_ps_q;
   logic          w_e_q;
   logic [26:0]   elo0_q, elo1_q;   // {PPN, G, MAT, PLV, D, V}
   logic [4:0]    inv_op_q;
   logic          srch_we_q, srch_ne_q, rd_we_q, rd_ne_q, done_q;
   logic [IW-1:0] fill_idx;

   // ELO bit 7 and bits 31:28 carry nothing the TLB stores.
   logic unused_elo;
   assign unused_elo = ^{csr_elo0_i[31:28], csr_elo0_i[7], csr_elo1_i[31:28], csr_elo1_i[7]};

`ifdef TLB_FILL_LFSR_EN
   logic [15:0] lfsr_q;
   always_ff @(posedge clk_i) begin
      if (reset_i) lfsr_q <= 16'hACE1;
      else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
   assign fill_idx = lfsr_q[IW-1:0];
`else
   logic [IW-1:0] fill_cnt_q;
   // Power-of-two entry count: natural wrap gives TLBNUM-1 -> 0.
   always_ff @(posedge clk_i) begin
      if (reset_i)                                 fill_cnt_q <= '0;
      else if (state_q == S_EXEC && op_q == OP_FILL) fill_cnt_q <= fill_cnt_q + 1'b1;
   end
   assign fill_idx = fill_cnt_q;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         err_q        <= 1'b0;
         s1_sel_q     <= 1'b0;
         s1_vppn_q    <= '0;
         s1_asid_q    <= '0;
         r_index_q    <= '0;
         we_q         <= 1'b0;
         w_index_q    <= '0;
         w_e_q        <= 1'b0;
         w_ps_q       <= '0;
         w_vppn_q     <= '0;
         w_asid_q     <= '0;
         elo0_q       <= '0;
         elo1_q       <= '0;
         inv_valid_q  <= 1'b0;
         inv_op_q     <= '0;
         srch_we_q    <= 1'b0;
         srch_ne_q    <= 1'b0;
         srch_index_q <= '0;
         rd_we_q      <= 1'b0;
         rd_ne_q      <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (op_valid_i) begin
                  state_q   <= S_EXEC;
                  op_q      <= op_code_i;
                  err_q     <= 1'b0;
                  w_e_q     <= ~csr_ne_i;
                  w_ps_q    <= csr_ps_i;
                  w_vppn_q  <= csr_ehi_vppn_i;
                  w_asid_q  <= csr_asid_i;
                  elo0_q    <= {csr_elo0_i[27:8], csr_elo0_i[6:0]};
                  elo1_q    <= {csr_elo1_i[27:8], csr_elo1_i[6:0]};
                  inv_op_q  <= inv_op_i;
                  case (op_code_i)
                     OP_SRCH: begin
                        s1_sel_q  <= 1'b1;
                        s1_vppn_q <= csr_ehi_vppn_i;
                        s1_asid_q <= csr_asid_i;
                     end
                     OP_RD:   r_index_q <= csr_idx_i;
                     OP_WR: begin
                        we_q      <= 1'b1;
                        w_index_q <= csr_idx_i;
                     end
                     OP_FILL: begin
                        we_q      <= 1'b1;
                        w_index_q <= fill_idx;
                     end
                     OP_INV: begin
                        s1_sel_q    <= 1'b1;
                        s1_vppn_q   <= inv_vppn_i;
                        s1_asid_q   <= inv_asid_i;
                        inv_valid_q <= (inv_op_i <= 5'd6);
                        err_q       <= (inv_op_i > 5'd6);
                     end
                     default: err_q <= 1'b1;
                  endcase
               end
            end
            S_EXEC: begin
               state_q     <= S_DONE;
               s1_sel_q    <= 1'b0;
               s1_vppn_q   <= '0;
               s1_asid_q   <= '0;
               we_q        <= 1'b0;
               inv_valid_q <= 1'b0;
               done_q      <= 1'b1;
               if (op_q == OP_SRCH) begin
                  srch_we_q    <= 1'b1;
                  srch_ne_q    <= ~tlb_s1_found_i;
                  srch_index_q <= tlb_s1_found_i ? tlb_s1_index_i : '0;
               end
               if (op_q == OP_RD) begin
                  rd_we_q <= 1'b1;
                  rd_ne_q <= ~tlb_r_e_i;
               end
            end
            default: begin
               state_q      <= S_IDLE;
               r_index_q    <= '0;
               done_q       <= 1'b0;
               err_q        <= 1'b0;
               srch_we_q    <= 1'b0;
               srch_ne_q    <= 1'b0;
               srch_index_q <= '0;
               rd_we_q      <= 1'b0;
               rd_ne_q      <= 1'b0;
            end
         endcase
      end
   end

   assign op_ready_o       = (state_q == S_IDLE);
   assign tlb_s1_sel_o     = s1_sel_q;
   assign tlb_s1_vppn_o    = s1_vppn_q;
   assign tlb_s1_asid_o    = s1_asid_q;
   assign tlb_r_index_o    = r_index_q;
   assign tlb_inv_valid_o  = inv_valid_q;
   assign tlb_inv_op_o     = s1_sel_q ? inv_op_q : 5'd0;

   // Write fields are only meaningful while the strobe is up; hold them at 0 otherwise.
   assign tlb_we_o         = we_q;
   assign tlb_w_index_o    = we_q ? w_index_q : '0;
   assign tlb_w_e_o        = we_q & w_e_q;
   assign tlb_w_ps_o       = we_q ? w_ps_q : '0;
   assign tlb_w_vppn_o     = we_q ? w_vppn_q : '0;
   assign tlb_w_asid_o     = we_q ? w_asid_q : '0;
   assign tlb_w_g_o        = we_q & elo0_q[6] & elo1_q[6];
   assign tlb_w_ppn0_o     = we_q ? elo0_q[26:7] : '0;
   assign tlb_w_mat0_o     = we_q ? elo0_q[5:4] : '0;
   assign tlb_w_plv0_o     = we_q ? elo0_q[3:2] : '0;
   assign tlb_w_d0_o       = we_q & elo0_q[1];
   assign tlb_w_v0_o       = we_q & elo0_q[0];
   assign tlb_w_ppn1_o     = we_q ? elo1_q[26:7] : '0;
   assign tlb_w_mat1_o     = we_q ? elo1_q[5:4] : '0;
   assign tlb_w_plv1_o     = we_q ? elo1_q[3:2] : '0;
   assign tlb_w_d1_o       = we_q & elo1_q[1];
   assign tlb_w_v1_o       = we_q & elo1_q[0];

   assign csr_srch_we_o    = srch_we_q;
   assign csr_srch_ne_o    = srch_ne_q;
   assign csr_srch_index_o = srch_index_q;
   assign csr_rd_we_o      = rd_we_q;
   assign csr_rd_ne_o      = rd_ne_q;
   assign done_o           = done_q;
   assign op_err_o         = err_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
module tb_tlb_op_ctrl;

   localparam int IW = 4;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          op_valid_i;
   logic          op_ready_o;
   logic [2:0]    op_code_i;
   logic [4:0]    inv_op_i;
   logic [9:0]    inv_asid_i;
   logic [18:0]   inv_vppn_i;
   logic [9:0]    csr_asid_i;
   logic [18:0]   csr_ehi_vppn_i;
   logic [IW-1:0] csr_idx_i;
   logic [5:0]    csr_ps_i;
   logic          csr_ne_i;
   logic [31:0]   csr_elo0_i, csr_elo1_i;
   logic          tlb_s1_sel_o;
   logic [18:0]   tlb_s1_vppn_o;
   logic [9:0]    tlb_s1_asid_o;
   logic          tlb_s1_found_i;
   logic [IW-1:0] tlb_s1_index_i;
   logic [IW-1:0] tlb_r_index_o;
   logic          tlb_r_e_i;
   logic          tlb_we_o;
   logic [IW-1:0] tlb_w_index_o;
   logic          tlb_w_e_o;
   logic [5:0]    tlb_w_ps_o;
   logic [18:0]   tlb_w_vppn_o;
   logic [9:0]    tlb_w_asid_o;
   logic          tlb_w_g_o;
   logic [19:0]   tlb_w_ppn0_o, tlb_w_ppn1_o;
   logic [1:0]    tlb_w_plv0_o, tlb_w_plv1_o, tlb_w_mat0_o, tlb_w_mat1_o;
   logic          tlb_w_d0_o, tlb_w_d1_o, tlb_w_v0_o, tlb_w_v1_o;
   logic          tlb_inv_valid_o;
   logic [4:0]    tlb_inv_op_o;
   logic          csr_srch_we_o, csr_srch_ne_o;
   logic [IW-1:0] csr_srch_index_o;
   logic          csr_rd_we_o, csr_rd_ne_o;
   logic          done_o, op_err_o;

   int compared = 0;
   int mismatched = 0;

   always #5 clk_i = ~clk_i;

   tlb_op_ctrl #(.TLBNUM(16)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_code_i(op_code_i),
      .inv_op_i(inv_op_i), .inv_asid_i(inv_asid_i), .inv_vppn_i(inv_vppn_i),
      .csr_asid_i(csr_asid_i), .csr_ehi_vppn_i(csr_ehi_vppn_i), .csr_idx_i(csr_idx_i),
      .csr_ps_i(csr_ps_i), .csr_ne_i(csr_ne_i), .csr_elo0_i(csr_elo0_i), .csr_elo1_i(csr_elo1_i),
      .tlb_s1_sel_o(tlb_s1_sel_o), .tlb_s1_vppn_o(tlb_s1_vppn_o), .tlb_s1_asid_o(tlb_s1_asid_o),
      .tlb_s1_found_i(tlb_s1_found_i), .tlb_s1_index_i(tlb_s1_index_i),
      .tlb_r_index_o(tlb_r_index_o), .tlb_r_e_i(tlb_r_e_i),
      .tlb_we_o(tlb_we_o), .tlb_w_index_o(tlb_w_index_o), .tlb_w_e_o(tlb_w_e_o),
      .tlb_w_ps_o(tlb_w_ps_o), .tlb_w_vppn_o(tlb_w_vppn_o), .tlb_w_asid_o(tlb_w_asid_o),
      .tlb_w_g_o(tlb_w_g_o),
      .tlb_w_ppn0_o(tlb_w_ppn0_o), .tlb_w_plv0_o(tlb_w_plv0_o), .tlb_w_mat0_o(tlb_w_mat0_o),
      .tlb_w_d0_o(tlb_w_d0_o), .tlb_w_v0_o(tlb_w_v0_o),
      .tlb_w_ppn1_o(tlb_w_ppn1_o), .tlb_w_plv1_o(tlb_w_plv1_o), .tlb_w_mat1_o(tlb_w_mat1_o),
      .tlb_w_d1_o(tlb_w_d1_o), .tlb_w_v1_o(tlb_w_v1_o),
      .tlb_inv_valid_o(tlb_inv_valid_o), .tlb_inv_op_o(tlb_inv_op_o),
      .csr_srch_we_o(csr_srch_we_o), .csr_srch_ne_o(csr_srch_ne_o),
      .csr_srch_index_o(csr_srch_index_o),
      .csr_rd_we_o(csr_rd_we_o), .csr_rd_ne_o(csr_rd_ne_o),
      .done_o(done_o), .op_err_o(op_err_o)
   );

   // Minimal 16-entry TLB stub: stores e/vppn/asid/g, answers s1 lookups and reads.
   logic        m_e [16];
   logic [18:0] m_vppn [16];
   logic [9:0]  m_asid [16];
   logic        m_g [16];

   initial begin
      for (int i = 0; i < 16; i++) begin
         m_e[i] = 1'b0; m_vppn[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0;
      end
   end

   always @(posedge clk_i) begin
      if (tlb_we_o) begin
         m_e[tlb_w_index_o]    <= tlb_w_e_o;
         m_vppn[tlb_w_index_o] <= tlb_w_vppn_o;
         m_asid[tlb_w_index_o] <= tlb_w_asid_o;
         m_g[tlb_w_index_o]    <= tlb_w_g_o;
      end
      if (tlb_inv_valid_o && tlb_inv_op_o <= 5'd1)
         for (int k = 0; k < 16; k++) m_e[k] <= 1'b0;
   end

   always_comb begin
      tlb_s1_found_i = 1'b0;
      tlb_s1_index_i = '0;
      for (int j = 0; j < 16; j++)
         if (m_e[j] && m_vppn[j] == tlb_s1_vppn_o && (m_g[j] || m_asid[j] == tlb_s1_asid_o)) begin
            tlb_s1_found_i = 1'b1;
            tlb_s1_index_i = j[IW-1:0];
         end
      tlb_r_e_i = m_e[tlb_r_index_o];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // From an IDLE-side negedge: request op, return at the EXEC negedge.
   task automatic issue(input logic [2:0] code);
      @(negedge clk_i);
      chk("ready_in_idle", {31'd0, op_ready_o}, 32'd1);
      op_valid_i = 1'b1;
      op_code_i  = code;
      @(negedge clk_i);
      op_valid_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b1; op_valid_i = 1'b0; op_code_i = '0;
      inv_op_i = '0; inv_asid_i = '0; inv_vppn_i = '0;
      csr_asid_i = 10'h021; csr_ehi_vppn_i = 19'h1234; csr_idx_i = 4'd5;
      csr_ps_i = 6'd12; csr_ne_i = 1'b0;
      csr_elo0_i = (32'hABC << 8) | 32'h43;   // G=1 D=1 V=1
      csr_elo1_i = (32'hDEF << 8) | 32'h01;   // G=0 V=1
      repeat (3) @(negedge clk_i);
      chk("rst_ready", {31'd0, op_ready_o}, 32'd1);
      chk("rst_we", {31'd0, tlb_we_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_sel", {31'd0, tlb_s1_sel_o}, 32'd0);
      chk("rst_inv", {31'd0, tlb_inv_valid_o}, 32'd0);
      reset_i = 1'b0;

      // WR idx 5; CSR index changes after accept must not leak in.
      issue(3'd2);
      csr_idx_i = 4'd9;
      chk("wr_we", {31'd0, tlb_we_o}, 32'd1);
      chk("wr_index", {28'd0, tlb_w_index_o}, 32'd5);
      chk("wr_e", {31'd0, tlb_w_e_o}, 32'd1);
      chk("wr_vppn", {13'd0, tlb_w_vppn_o}, 32'h1234);
      chk("wr_ps", {26'd0, tlb_w_ps_o}, 32'd12);
      chk("wr_asid", {22'd0, tlb_w_asid_o}, 32'h21);
      chk("wr_g", {31'd0, tlb_w_g_o}, 32'd0);
      chk("wr_ppn0", {12'd0, tlb_w_ppn0_o}, 32'hABC);
      chk("wr_ppn1", {12'd0, tlb_w_ppn1_o}, 32'hDEF);
      chk("wr_d0", {31'd0, tlb_w_d0_o}, 32'd1);
      chk("wr_d1", {31'd0, tlb_w_d1_o}, 32'd0);
      chk("wr_ready_exec", {31'd0, op_ready_o}, 32'd0);
      chk("wr_done_early", {31'd0, done_o}, 32'd0);
      @(negedge clk_i);
      chk("wr_we_off", {31'd0, tlb_we_o}, 32'd0);
      chk("wr_done", {31'd0, done_o}, 32'd1);
      chk("wr_err", {31'd0, op_err_o}, 32'd0);

      // SRCH hit
      issue(3'd0);
      chk("srch_sel", {31'd0, tlb_s1_sel_o}, 32'd1);
      chk("srch_vppn", {13'd0, tlb_s1_vppn_o}, 32'h1234);
      chk("srch_asid", {22'd0, tlb_s1_asid_o}, 32'h21);
      @(negedge clk_i);
      chk("srch_we", {31'd0, csr_srch_we_o}, 32'd1);
      chk("srch_ne", {31'd0, csr_srch_ne_o}, 32'd0);
      chk("srch_idx", {28'd0, csr_srch_index_o}, 32'd5);
      chk("srch_sel_off", {31'd0, tlb_s1_sel_o}, 32'd0);

      // SRCH miss
      csr_ehi_vppn_i = 19'h5555;
      issue(3'd0);
      @(negedge clk_i);
      chk("miss_we", {31'd0, csr_srch_we_o}, 32'd1);
      chk("miss_ne", {31'd0, csr_srch_ne_o}, 32'd1);
      chk("miss_idx", {28'd0, csr_srch_index_o}, 32'd0);

      // RD idx 5 (valid) then idx 3 (empty)
      csr_idx_i = 4'd5;
      issue(3'd1);
      chk("rd_idx_exec", {28'd0, tlb_r_index_o}, 32'd5);
      @(negedge clk_i);
      chk("rd_idx_done", {28'd0, tlb_r_index_o}, 32'd5);
      chk("rd_we", {31'd0, csr_rd_we_o}, 32'd1);
      chk("rd_ne", {31'd0, csr_rd_ne_o}, 32'd0);
      csr_idx_i = 4'd3;
      issue(3'd1);
      @(negedge clk_i);
      chk("rd_empty_ne", {31'd0, csr_rd_ne_o}, 32'd1);

      // 17 back-to-back FILLs: round-robin 0..15, 0
      for (int i = 0; i < 17; i++) begin
         csr_ehi_vppn_i = 19'h100 + 19'(i);
         issue(3'd3);
         chk("fill_we", {31'd0, tlb_we_o}, 32'd1);
         chk("fill_index", {28'd0, tlb_w_index_o}, 32'(i % 16));
         chk("fill_ready_exec", {31'd0, op_ready_o}, 32'd0);
         @(negedge clk_i);
         chk("fill_ready_done", {31'd0, op_ready_o}, 32'd0);
         chk("fill_done", {31'd0, done_o}, 32'd1);
      end

      // INV op 0, then every entry reads empty
      inv_op_i = 5'd0; inv_vppn_i = 19'h7777; inv_asid_i = 10'h3;
      issue(3'd4);
      chk("inv_valid", {31'd0, tlb_inv_valid_o}, 32'd1);
      chk("inv_sel", {31'd0, tlb_s1_sel_o}, 32'd1);
      chk("inv_vppn", {13'd0, tlb_s1_vppn_o}, 32'h7777);
      chk("inv_asid", {22'd0, tlb_s1_asid_o}, 32'h3);
      chk("inv_op", {27'd0, tlb_inv_op_o}, 32'd0);
      @(negedge clk_i);
      chk("inv_valid_off", {31'd0, tlb_inv_valid_o}, 32'd0);
      chk("inv_done", {31'd0, done_o}, 32'd1);
      chk("inv_err", {31'd0, op_err_o}, 32'd0);
      csr_idx_i = 4'd5;
      issue(3'd1);
      @(negedge clk_i);
      chk("rd_after_inv_ne", {31'd0, csr_rd_ne_o}, 32'd1);

      // INV op 7: rejected
      inv_op_i = 5'd7;
      issue(3'd4);
      chk("inv7_valid", {31'd0, tlb_inv_valid_o}, 32'd0);
      @(negedge clk_i);
      chk("inv7_done", {31'd0, done_o}, 32'd1);
      chk("inv7_err", {31'd0, op_err_o}, 32'd1);

      // Reserved op code
      issue(3'd5);
      chk("rsv_we", {31'd0, tlb_we_o}, 32'd0);
      chk("rsv_sel", {31'd0, tlb_s1_sel_o}, 32'd0);
      chk("rsv_inv", {31'd0, tlb_inv_valid_o}, 32'd0);
      @(negedge clk_i);
      chk("rsv_done", {31'd0, done_o}, 32'd1);
      chk("rsv_err", {31'd0, op_err_o}, 32'd1);

      // Reset during EXEC of WR
      csr_idx_i = 4'd7;
      issue(3'd2);
      chk("rstmid_we_exec", {31'd0, tlb_we_o}, 32'd1);
      reset_i = 1'b1;
      @(negedge clk_i);
      chk("rstmid_we", {31'd0, tlb_we_o}, 32'd0);
      chk("rstmid_ready", {31'd0, op_ready_o}, 32'd1);
      chk("rstmid_done", {31'd0, done_o}, 32'd0);
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("rstmid_we_after", {31'd0, tlb_we_o}, 32'd0);
      chk("rstmid_done_after", {31'd0, done_o}, 32'd0);
      chk("rstmid_ready_after", {31'd0, op_ready_o}, 32'd1);

      // Fill counter restarts at 0 after reset
      issue(3'd3);
      chk("fill_after_rst", {28'd0, tlb_w_index_o}, 32'd0);
      @(negedge clk_i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
